// File: rtl/req_initiator.sv
// Requesting side of the single-line req/gnt handshake: request, own for len+1 cycles, release.
// Optional retry-with-backoff after a request timeout is compiled in with REQ_INIT_RETRY_EN.
module req_initiator #(
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned BACKOFF   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic             gnt,
  output logic             req,
  output logic             owned,
  output logic             done,
  output logic             err_timeout,
  output logic             err_lost
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_REL,
    S_ERR
`ifdef REQ_INIT_RETRY_EN
    ,S_BACKOFF
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    own_cnt_q, own_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                lost_q, lost_d;
  logic                req_q, req_d;
  logic                owned_q, owned_d;
  logic                done_q, done_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_lost_q, err_lost_d;

`ifdef REQ_INIT_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned BO_W  = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [BO_W-1:0]  bo_cnt_q, bo_cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(MAX_RETRY), 32'(BACKOFF)};
`endif

  assign start_ready = (state_q == S_IDLE);
  assign req         = req_q;
  assign owned       = owned_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_lost    = err_lost_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    own_cnt_d     = own_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    lost_d        = lost_q;
    done_d        = 1'b0;
    err_timeout_d = 1'b0;
    err_lost_d    = 1'b0;
`ifdef REQ_INIT_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
    bo_cnt_d      = bo_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        lost_d = 1'b0;
`ifdef REQ_INIT_RETRY_EN
        retry_cnt_d = '0;
`endif
        if (start_valid) begin
          len_d      = start_len;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // A grant in the final wait cycle still wins over the timeout
        if (gnt) begin
          own_cnt_d = len_q;
          state_d   = S_OWN;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
`ifdef REQ_INIT_RETRY_EN
          if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + RTY_W'(1);
            bo_cnt_d    = BO_W'(BACKOFF - 1);
            state_d     = S_BACKOFF;
          end else begin
            err_timeout_d = 1'b1;
            state_d       = S_ERR;
          end
`else
          err_timeout_d = 1'b1;
          state_d       = S_ERR;
`endif
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_OWN: begin
        if (!gnt) begin
          err_lost_d = 1'b1;
          lost_d     = 1'b1;
          state_d    = S_REL;
        end else if (own_cnt_q == '0) begin
          state_d = S_REL;
        end else begin
          own_cnt_d = own_cnt_q - LEN_W'(1);
        end
      end
      S_REL: begin
        if (!gnt) begin
          done_d  = ~lost_q;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
`ifdef REQ_INIT_RETRY_EN
      S_BACKOFF: begin
        if (bo_cnt_q == '0) begin
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end else begin
          bo_cnt_d = bo_cnt_q - BO_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d   = (state_d == S_REQ) || (state_d == S_OWN);
    owned_d = (state_d == S_OWN);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      own_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      lost_q        <= 1'b0;
      req_q         <= 1'b0;
      owned_q       <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_lost_q    <= 1'b0;
`ifdef REQ_INIT_RETRY_EN
      retry_cnt_q   <= '0;
      bo_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      own_cnt_q     <= own_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      lost_q        <= lost_d;
      req_q         <= req_d;
      owned_q       <= owned_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_lost_q    <= err_lost_d;
`ifdef REQ_INIT_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
      bo_cnt_q      <= bo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_req_initiator.sv
// Bench for req_initiator: per-transfer waveform model built from event times, checked every cycle.
module tb_req_initiator;

  localparam int unsigned LEN_W     = 4;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned MAX_RETRY = 1;
  localparam int unsigned BACKOFF   = 4;
  localparam int          NCYC      = 64;
`ifdef REQ_INIT_RETRY_EN
  localparam int          RETRIES   = MAX_RETRY;
`else
  localparam int          RETRIES   = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             gnt;
  logic             req;
  logic             owned;
  logic             done;
  logic             err_timeout;
  logic             err_lost;

  int checks   = 0;
  int failures = 0;

  bit exp_req [NCYC];
  bit exp_own [NCYC];
  bit exp_done[NCYC];
  bit exp_errt[NCYC];
  bit exp_errl[NCYC];
  bit exp_rdy [NCYC];
  int model_idle;
  int cur_on, cur_off;

  int st_own, st_req, st_errt, st_errt_at, st_done_at, st_errl_at;

  req_initiator #(
    .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)
  ) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .start_len(start_len), .gnt(gnt), .req(req), .owned(owned), .done(done),
    .err_timeout(err_timeout), .err_lost(err_lost)
  );

  always #5 clk = ~clk;

  function automatic bit gv(int k);
    return bit'(k >= cur_on && k < cur_off);
  endfunction

  function automatic logic [5:0] dut_vec();
    return {req, owned, done, err_timeout, err_lost, start_ready};
  endfunction

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_vec(string name, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s {req,owned,done,errt,errl,rdy} actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Cycle k = k-th cycle after the accept edge; gnt in cycle k is gv(k)
  task automatic build_model(int len);
    int s, g, e, r, tries;
    bit lost, fin;
    for (int k = 0; k < NCYC; k++) begin
      exp_req[k] = 0; exp_own[k] = 0; exp_done[k] = 0;
      exp_errt[k] = 0; exp_errl[k] = 0; exp_rdy[k] = 0;
    end
    s = 0; tries = 0; fin = 0; model_idle = 0;
    while (!fin) begin
      g = -1;
      for (int k = s; k < s + int'(TIMEOUT); k++)
        if (g < 0 && gv(k)) g = k;
      if (g < 0) begin
        for (int k = s; k < s + int'(TIMEOUT); k++) exp_req[k] = 1;
        if (tries < RETRIES) begin
          tries++;
          s = s + int'(TIMEOUT) + int'(BACKOFF);
        end else begin
          exp_errt[s + int'(TIMEOUT)] = 1;
          model_idle = s + int'(TIMEOUT) + 1;
          fin = 1;
        end
      end else begin
        for (int k = s; k <= g; k++) exp_req[k] = 1;
        lost = 0;
        e = g + 2 + len;
        for (int c = g + 1; c <= g + 1 + len; c++)
          if (!lost && !gv(c)) begin lost = 1; e = c + 1; end
        for (int c = g + 1; c < e; c++) begin exp_req[c] = 1; exp_own[c] = 1; end
        if (lost) exp_errl[e] = 1;
        r = e;
        while (gv(r)) r++;
        model_idle = r + 1;
        if (!lost) exp_done[model_idle] = 1;
        fin = 1;
      end
    end
    for (int k = model_idle; k < NCYC; k++) exp_rdy[k] = 1;
  endtask

  // Entered and left at #1 after a rising edge; stop_at<0 runs the full transfer
  task automatic run(string name, int len, int on, int off, int stop_at);
    int last;
    cur_on = on; cur_off = off;
    build_model(len);
    last = (stop_at >= 0) ? stop_at : model_idle + 2;
    st_own = 0; st_req = 0; st_errt = 0;
    st_errt_at = -1; st_done_at = -1; st_errl_at = -1;
    check_vec({name, " idle"}, dut_vec(), 6'b000001);
    start_valid = 1'b1;
    start_len   = LEN_W'(len);
    gnt         = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    start_len   = ~LEN_W'(len);
    for (int k = 0; k < last; k++) begin
      check_vec($sformatf("%s c%0d", name, k), dut_vec(),
                {exp_req[k], exp_own[k], exp_done[k], exp_errt[k], exp_errl[k], exp_rdy[k]});
      if (owned) st_own++;
      if (req) st_req++;
      if (err_timeout) begin st_errt++; if (st_errt_at < 0) st_errt_at = k; end
      if (done && st_done_at < 0) st_done_at = k;
      if (err_lost && st_errl_at < 0) st_errl_at = k;
      gnt = gv(k);
      @(posedge clk); #1;
    end
    gnt = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; start_len = '0; gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset", dut_vec(), 6'b000001);
    rst = 1'b0;
    @(posedge clk); #1;

    run("basic", 2, 2, 7, -1);
    check_int("basic owned_cycles", st_own, 3);
    check_int("basic req_cycles", st_req, 6);
    check_int("basic done_cycle", st_done_at, 8);

    run("timeout", 0, 0, 0, -1);
    check_int("timeout done_cycle", st_done_at, -1);
    check_int("timeout errt_pulses", st_errt, 1);
`ifdef REQ_INIT_RETRY_EN
    check_int("timeout req_cycles", st_req, 16);
    check_int("timeout errt_cycle", st_errt_at, 20);
`else
    check_int("timeout req_cycles", st_req, 8);
    check_int("timeout errt_cycle", st_errt_at, 8);
`endif

    run("late_gnt", 0, 14, 17, -1);
`ifdef REQ_INIT_RETRY_EN
    check_int("late_gnt done_cycle", st_done_at, 18);
    check_int("late_gnt errt_pulses", st_errt, 0);
`else
    check_int("late_gnt done_cycle", st_done_at, -1);
    check_int("late_gnt errt_cycle", st_errt_at, 8);
`endif

    run("lost", 5, 2, 4, -1);
    check_int("lost owned_cycles", st_own, 2);
    check_int("lost errl_cycle", st_errl_at, 5);
    check_int("lost done_cycle", st_done_at, -1);

    run("edge_gnt", 0, 7, 9, -1);
    check_int("edge_gnt done_cycle", st_done_at, 10);
    check_int("edge_gnt errt_pulses", st_errt, 0);

    run("len15", 15, 1, 30, -1);
    check_int("len15 owned_cycles", st_own, 16);
    check_int("len15 done_cycle", st_done_at, 31);

    run("rst_own", 2, 2, 7, 5);
    #2 rst = 1'b1;
    #1 check_vec("rst_own async", dut_vec(), 6'b000001);
    @(posedge clk); #1;
    check_vec("rst_own held", dut_vec(), 6'b000001);
    rst = 1'b0;
    @(posedge clk); #1;
    run("after_rst", 2, 2, 7, -1);
    check_int("after_rst owned_cycles", st_own, 3);
    check_int("after_rst done_cycle", st_done_at, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
